int2015diff: RTL and testbench

//  Inverse of the INT accumulator path: takes a stream of 20-bit running sums and

---
 rtl/int2015diff.sv | 155 +++++++++++++++
 tb/tb_int2015diff.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/int2015diff.sv
// int2015diff: recovers per-step increments from a stream of running accumulator sums.
//
// Each accepted sample produces delta = (in_sum - prev) mod 2^IN_W. Deltas that do not
// fit in OUT_W bits are saturated to all-ones and flagged. Results pass through a
// 2-entry output buffer so that in_ready is a plain register.
//
// Ports:
//   clk        : clock, all logic on posedge
//   rst        : asynchronous active-high reset
//   clear      : synchronous restart (prev <- 0, buffer flushed, sticky cleared)
//   in_valid   : in_sum is valid
//   in_ready   : block can accept a sample (registered, = count != 2)
//   in_sum     : running accumulator value, unsigned IN_W bits
//   out_valid  : head entry valid (= count != 0)
//   out_ready  : downstream accepts head entry
//   out_delta  : recovered increment, saturated to all-ones on overflow
//   out_ovf    : head entry's true delta was >= 2^OUT_W
//   ovf_sticky : set by any overflowed accepted sample, cleared by rst/clear
module int2015diff #(
    parameter int unsigned IN_W  = 20,
    parameter int unsigned OUT_W = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_sum,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_delta,
    output logic             out_ovf,
    output logic             ovf_sticky
);

    // Buffer occupancy doubles as the FSM state.
    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StTwo   = 2'd2
    } state_e;

    state_e             r_state;
    state_e             w_state_d;
    logic               r_in_ready;
    logic [IN_W-1:0]    r_prev;
    logic               r_sticky;
    logic [OUT_W-1:0]   r_head_delta;
    logic               r_head_ovf;
    logic [OUT_W-1:0]   r_tail_delta;
    logic               r_tail_ovf;

    logic               w_accept;
    logic               w_pop;
    logic [IN_W-1:0]    w_raw;
    logic               w_ovf;
    logic [OUT_W-1:0]   w_delta;
    logic               w_load_head;
    logic               w_load_tail;
    logic               w_shift;

    assign out_valid  = (r_state != StEmpty);
    assign in_ready   = r_in_ready;
    assign out_delta  = r_head_delta;
    assign out_ovf    = r_head_ovf;
    assign ovf_sticky = r_sticky;

    // Next-state and datapath controls.
    always_comb begin
        w_accept    = in_valid & r_in_ready;
        w_pop       = out_valid & out_ready;
        // Borrow discarded: accumulator wrap-around yields the correct delta.
        w_raw       = in_sum - r_prev;
        w_ovf       = |w_raw[IN_W-1:OUT_W];
        w_delta     = w_ovf ? {OUT_W{1'b1}} : w_raw[OUT_W-1:0];
        w_state_d   = r_state;
        w_load_head = 1'b0;
        w_load_tail = 1'b0;
        w_shift     = 1'b0;
        if (clear) begin
            w_state_d = StEmpty;
        end else begin
            unique case (r_state)
                StEmpty: begin
                    if (w_accept) begin
                        w_state_d   = StOne;
                        w_load_head = 1'b1;
                    end
                end
                StOne: begin
                    if (w_accept && !w_pop) begin
                        w_state_d   = StTwo;
                        w_load_tail = 1'b1;
                    end else if (w_accept && w_pop) begin
                        w_load_head = 1'b1;
                    end else if (w_pop) begin
                        w_state_d = StEmpty;
                    end
                end
                StTwo: begin
                    // in_ready is low here, so only a pop can happen.
                    if (w_pop) begin
                        w_state_d = StOne;
                        w_shift   = 1'b1;
                    end
                end
                default: w_state_d = StEmpty;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= StEmpty;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_state_d;
            r_in_ready <= (w_state_d != StTwo);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev       <= '0;
            r_sticky     <= 1'b0;
            r_head_delta <= '0;
            r_head_ovf   <= 1'b0;
            r_tail_delta <= '0;
            r_tail_ovf   <= 1'b0;
        end else if (clear) begin
            // Head holds its value so the outputs stay stable while empty.
            r_prev   <= '0;
            r_sticky <= 1'b0;
        end else begin
            if (w_accept) begin
                r_prev <= in_sum;
                if (w_ovf) begin
                    r_sticky <= 1'b1;
                end
            end
            if (w_load_head) begin
                r_head_delta <= w_delta;
                r_head_ovf   <= w_ovf;
            end else if (w_shift) begin
                r_head_delta <= r_tail_delta;
                r_head_ovf   <= r_tail_ovf;
            end
            if (w_load_tail) begin
                r_tail_delta <= w_delta;
                r_tail_ovf   <= w_ovf;
            end
        end
    end

endmodule

// File: tb/tb_int2015diff.sv
module tb_int2015diff;

    localparam int unsigned IN_W  = 20;
    localparam int unsigned OUT_W = 15;

    logic             clk;
    logic             rst;
    logic             clear;
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_sum;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_delta;
    logic             out_ovf;
    logic             ovf_sticky;

    int n_cmp = 0;
    int n_err = 0;

    int2015diff #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sum    (in_sum),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_delta (out_delta),
        .out_ovf   (out_ovf),
        .ovf_sticky(ovf_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a queue of {delta, ovf} entries plus the reference sum.
    logic [15:0]     m_q[$];
    logic [15:0]     m_last;
    logic [IN_W-1:0] m_prev;
    logic            m_sticky;
    logic [14:0]     inc_q[$];
    logic            chk_inc = 1'b0;

    always @(negedge clk) begin
        logic [IN_W-1:0] raw;
        logic            ovf;
        logic [15:0]     e;
        logic [14:0]     g;
        if (rst) begin
            m_q.delete();
            m_prev   = '0;
            m_sticky = 1'b0;
            m_last   = '0;
        end else begin
            check("out_valid", out_valid, m_q.size() != 0);
            check("in_ready", in_ready, m_q.size() != 2);
            check("ovf_sticky", ovf_sticky, m_sticky);
            e = (m_q.size() != 0) ? m_q[0] : m_last;
            check("out_delta", out_delta, e[15:1]);
            check("out_ovf", out_ovf, e[0]);
            if (chk_inc && out_valid && out_ready) begin
                if (inc_q.size() == 0) begin
                    check("inc_stream_extra", 1, 0);
                end else begin
                    g = inc_q.pop_front();
                    check("inc_stream", out_delta, g);
                end
            end
            // Advance the model across the coming edge.
            if (clear) begin
                if (m_q.size() != 0) m_last = m_q[0];
                m_q.delete();
                m_prev   = '0;
                m_sticky = 1'b0;
            end else begin
                logic acc;
                acc = in_valid && (m_q.size() < 2);
                if (out_ready && m_q.size() != 0) m_last = m_q.pop_front();
                if (acc) begin
                    raw = in_sum - m_prev;
                    ovf = (raw >= (1 << OUT_W));
                    m_q.push_back({ovf ? 15'h7FFF : raw[14:0], ovf});
                    m_prev   = in_sum;
                    m_sticky = m_sticky | ovf;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [IN_W-1:0] s, input logic r);
        in_valid  = v;
        in_sum    = s;
        out_ready = r;
    endtask

    initial begin
        logic [IN_W-1:0] acc;
        logic [14:0]     inc;
        logic            pending;
        logic            will;
        int              sent;
        int              cyc;

        rst = 1'b1; clear = 1'b0;
        drive(1'b0, '0, 1'b0);
        #2;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_delta", out_delta, 0);
        check("rst_out_ovf", out_ovf, 0);
        check("rst_sticky", ovf_sticky, 0);
        step();
        step();
        rst = 1'b0;
        step();

        // Basic deltas, one cycle after accept.
        drive(1'b1, 20'h00005, 1'b1); step();
        check("t1_d5", out_delta, 5); check("t1_v", out_valid, 1);
        drive(1'b1, 20'h0000C, 1'b1); step();
        check("t1_d7", out_delta, 7);
        drive(1'b1, 20'h0000C, 1'b1); step();
        check("t1_d0", out_delta, 0); check("t1_ovf", out_ovf, 0);
        drive(1'b0, '0, 1'b1); step();

        // Wrap-around of the accumulator.
        drive(1'b1, 20'hFFFF0, 1'b1); step();
        drive(1'b1, 20'h00010, 1'b1); step();
        check("t2_wrap", out_delta, 15'h0020); check("t2_ovf", out_ovf, 0);
        drive(1'b0, '0, 1'b1); clear = 1'b1; step();
        clear = 1'b0;

        // Overflow saturation and sticky flag.
        drive(1'b1, 20'h08000, 1'b1); step();
        check("t3_sat", out_delta, 15'h7FFF); check("t3_ovf", out_ovf, 1);
        check("t3_sticky", ovf_sticky, 1);
        drive(1'b1, 20'h08003, 1'b1); step();
        check("t3_d3", out_delta, 3); check("t3_ovf0", out_ovf, 0);
        check("t3_sticky_hold", ovf_sticky, 1);
        drive(1'b0, '0, 1'b1); step();

        // Backpressure.
        drive(1'b1, 20'h08010, 1'b0); step();
        check("t4_rdy1", in_ready, 1);
        drive(1'b1, 20'h08020, 1'b0); step();
        check("t4_full", in_ready, 0);
        drive(1'b1, 20'h08025, 1'b0); step();
        check("t4_still_full", in_ready, 0); check("t4_headA", out_delta, 15'h000D);
        drive(1'b1, 20'h08025, 1'b1); step();
        check("t4_rdy_after_pop", in_ready, 1); check("t4_headB", out_delta, 15'h0010);
        step();
        check("t4_headC", out_delta, 5); check("t4_v", out_valid, 1);
        drive(1'b0, '0, 1'b1); step();
        check("t4_empty", out_valid, 0);

        // clear while full with in_valid high.
        drive(1'b1, 20'h08030, 1'b0); step();
        drive(1'b1, 20'h08040, 1'b0); step();
        check("t5_full", in_ready, 0);
        drive(1'b1, 20'h12345, 1'b0); clear = 1'b1; step();
        clear = 1'b0;
        check("t5_empty", out_valid, 0); check("t5_sticky", ovf_sticky, 0);
        drive(1'b1, 20'h00009, 1'b1); step();
        check("t5_d9", out_delta, 9);
        drive(1'b0, '0, 1'b1); step();

        // Asynchronous reset mid-stream drops buffered entries at once.
        drive(1'b1, 20'h00100, 1'b0); step();
        drive(1'b0, '0, 1'b0);
        rst = 1'b1; #1;
        check("rst_mid_valid", out_valid, 0);
        step();
        rst = 1'b0;
        step();

        // Random ready/valid against a golden accumulator.
        chk_inc = 1'b1;
        acc = '0; pending = 1'b0; sent = 0; cyc = 0; inc = '0;
        while (sent < 10000 && cyc < 60000) begin
            if (!pending) begin
                inc = 15'($urandom);
                if ($urandom_range(0, 15) == 0) inc = 15'h7FFF;
                pending = 1'b1;
            end
            in_valid  = ($urandom_range(0, 99) < 70);
            in_sum    = acc + IN_W'(inc);
            out_ready = ($urandom_range(0, 99) < 70);
            will = in_valid && in_ready;
            step();
            cyc++;
            if (will) begin
                acc = acc + IN_W'(inc);
                inc_q.push_back(inc);
                sent++;
                pending = 1'b0;
            end
        end
        check("t6_all_sent", sent, 10000);
        in_valid = 1'b0; out_ready = 1'b1;
        cyc = 0;
        while ((inc_q.size() != 0 || out_valid) && cyc < 100) begin
            step();
            cyc++;
        end
        check("t6_drained", inc_q.size(), 0);
        chk_inc = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
